// File: rtl/stepper_step_decoder_if.sv
// rtl/stepper_step_decoder_if.sv - control/status bundle for the step/dir decoder
//
// Signals:
//   enable, clear        control from the host
//   step_in, dir_in      raw asynchronous step/dir lines
//   position             sign-magnitude step count ([31] = negative)
//   step_strobe          one-cycle pulse per accepted step
//   moving, step_period  activity flag and last step interval
//   overspeed_err, dir_err, overflow_err   sticky protocol flags
// Modports: master drives control and lines, slave is the decoder.

interface stepper_step_decoder_if;
  logic        enable;
  logic        clear;
  logic        step_in;
  logic        dir_in;
  logic [31:0] position;
  logic        step_strobe;
  logic        moving;
  logic [31:0] step_period;
  logic        overspeed_err;
  logic        dir_err;
  logic        overflow_err;

  modport master (
    output enable, clear, step_in, dir_in,
    input  position, step_strobe, moving, step_period,
    input  overspeed_err, dir_err, overflow_err
  );

  modport slave (
    input  enable, clear, step_in, dir_in,
    output position, step_strobe, moving, step_period,
    output overspeed_err, dir_err, overflow_err
  );
endinterface

// File: rtl/stepper_step_decoder.sv
// rtl/stepper_step_decoder.sv - step/dir receiver with signed position count
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    stepper_step_decoder_if.slave (control in, lines in, status out)
// Parameters:
//   SYNC_STAGES  synchronizer depth on step_in/dir_in (2..4)
//   MIN_PERIOD   minimum clocks between steps before overspeed_err
//   DIR_SETUP    clocks dir must be stable before a step
//   TIMEOUT      idle clocks before moving drops
//   POS_WIDTH    saturation width of the count; 32 gives +/-(2^31-1),
//                smaller values saturate earlier for short test runs
// Build option:
//   STEPPER_STEP_DECODER_PERIOD_EN  builds gap/step_period/moving/overspeed_err;
//   when undefined those outputs are tied to 0.

module stepper_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4,
  parameter int DIR_SETUP   = 2,
  parameter int TIMEOUT     = 1000000,
  parameter int POS_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stepper_step_decoder_if.slave  bus
);

  localparam int                AGE_W     = $clog2(DIR_SETUP + 2);
  localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(DIR_SETUP);
  localparam logic [31:0]       POS_MAX_U = (32'd1 << (POS_WIDTH - 1)) - 32'd1;
  localparam logic signed [31:0] POS_MAX  = $signed(POS_MAX_U);
  localparam logic signed [31:0] POS_MIN  = -POS_MAX;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || MIN_PERIOD < 1 || TIMEOUT < 1 ||
      DIR_SETUP < 0 || POS_WIDTH < 2 || POS_WIDTH > 32) begin : g_bad_params
    $error("stepper_step_decoder: parameter out of range");
  end

  // Synchronizers and previous-sample registers
  logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
  logic [SYNC_STAGES-1:0] dir_sync_q,  dir_sync_d;
  logic                   step_prev_q, step_prev_d;
  logic                   dir_prev_q,  dir_prev_d;
  logic [AGE_W-1:0]       dir_age_q,   dir_age_d;

  // Count and flags
  logic signed [31:0]     pos_q, pos_d;
  logic                   step_strobe_q, step_strobe_d;
  logic                   dir_err_q, dir_err_d;
  logic                   overflow_err_q, overflow_err_d;

  logic                   sync_step;
  logic                   sync_dir;
  logic                   step_edge;
  logic                   step_accept;
  logic                   dir_changed;
  logic [AGE_W-1:0]       dir_age_now;
  logic                   at_limit;
  logic [31:0]            pos_mag;

  always_comb begin
    step_sync_d = {step_sync_q[SYNC_STAGES-2:0], bus.step_in};
    dir_sync_d  = {dir_sync_q[SYNC_STAGES-2:0],  bus.dir_in};

    sync_step   = step_sync_q[SYNC_STAGES-1];
    sync_dir    = dir_sync_q[SYNC_STAGES-1];

    // Previous samples track the line regardless of enable/clear, so a
    // line held high across a clear or a disable never looks like an edge.
    step_prev_d = sync_step;
    dir_prev_d  = sync_dir;

    step_edge   = sync_step & ~step_prev_q;
    step_accept = step_edge & bus.enable & ~bus.clear;

    // Age of the current synced dir: 0 in the cycle it changes, so a step
    // that coincides with the change is always flagged.
    dir_changed = sync_dir ^ dir_prev_q;
    dir_age_now = dir_changed ? '0 : dir_age_q;
    dir_age_d   = (dir_age_now < AGE_MAX) ? dir_age_now + AGE_W'(1) : dir_age_now;

    at_limit    = sync_dir ? (pos_q == POS_MIN) : (pos_q == POS_MAX);

    pos_d          = pos_q;
    step_strobe_d  = 1'b0;
    dir_err_d      = dir_err_q;
    overflow_err_d = overflow_err_q;

    if (bus.clear) begin
      pos_d          = '0;
      dir_err_d      = 1'b0;
      overflow_err_d = 1'b0;
    end else if (step_accept) begin
      step_strobe_d = 1'b1;
      if (dir_age_now < AGE_MAX) begin
        dir_err_d = 1'b1;
      end
      if (at_limit) begin
        overflow_err_d = 1'b1;
      end else if (sync_dir) begin
        pos_d = pos_q - 32'sd1;
      end else begin
        pos_d = pos_q + 32'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q    <= '0;
      dir_sync_q     <= '0;
      step_prev_q    <= 1'b0;
      dir_prev_q     <= 1'b0;
      // Lines are treated as settled out of reset.
      dir_age_q      <= AGE_MAX;
      pos_q          <= '0;
      step_strobe_q  <= 1'b0;
      dir_err_q      <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      step_sync_q    <= step_sync_d;
      dir_sync_q     <= dir_sync_d;
      step_prev_q    <= step_prev_d;
      dir_prev_q     <= dir_prev_d;
      dir_age_q      <= dir_age_d;
      pos_q          <= pos_d;
      step_strobe_q  <= step_strobe_d;
      dir_err_q      <= dir_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Sign-magnitude view; pos never reaches -2^31 so the magnitude fits in
  // 31 bits and a zero count always has a clear sign bit.
  always_comb begin
    pos_mag = pos_q[31] ? (32'd0 - pos_q) : pos_q;
  end

  assign bus.position     = {pos_q[31], pos_mag[30:0]};
  assign bus.step_strobe  = step_strobe_q;
  assign bus.dir_err      = dir_err_q;
  assign bus.overflow_err = overflow_err_q;

`ifdef STEPPER_STEP_DECODER_PERIOD_EN
  logic [31:0] gap_q, gap_d;
  logic [31:0] step_period_q, step_period_d;
  logic        have_edge_q, have_edge_d;
  logic        moving_q, moving_d;
  logic        overspeed_err_q, overspeed_err_d;
  logic [31:0] gap_inc;

  always_comb begin
    gap_inc         = (gap_q == '1) ? gap_q : gap_q + 32'd1;
    gap_d           = gap_q;
    step_period_d   = step_period_q;
    have_edge_d     = have_edge_q;
    moving_d        = moving_q;
    overspeed_err_d = overspeed_err_q;

    if (bus.clear) begin
      gap_d           = '0;
      step_period_d   = '0;
      have_edge_d     = 1'b0;
      moving_d        = 1'b0;
      overspeed_err_d = 1'b0;
    end else if (step_accept) begin
      // gap_inc is the interval ending at this edge.
      gap_d       = '0;
      have_edge_d = 1'b1;
      moving_d    = 1'b1;
      if (have_edge_q) begin
        step_period_d = gap_inc;
        if (gap_inc < 32'(MIN_PERIOD)) begin
          overspeed_err_d = 1'b1;
        end
      end
    end else begin
      gap_d = gap_inc;
      if (gap_inc == 32'(TIMEOUT)) begin
        moving_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q           <= '0;
      step_period_q   <= '0;
      have_edge_q     <= 1'b0;
      moving_q        <= 1'b0;
      overspeed_err_q <= 1'b0;
    end else begin
      gap_q           <= gap_d;
      step_period_q   <= step_period_d;
      have_edge_q     <= have_edge_d;
      moving_q        <= moving_d;
      overspeed_err_q <= overspeed_err_d;
    end
  end

  assign bus.step_period   = step_period_q;
  assign bus.moving        = moving_q;
  assign bus.overspeed_err = overspeed_err_q;
`else
  assign bus.step_period   = '0;
  assign bus.moving        = 1'b0;
  assign bus.overspeed_err = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_step_decoder.sv
// tb/tb_stepper_step_decoder.sv - directed scoreboard bench for stepper_step_decoder

module tb_stepper_step_decoder;

`ifdef STEPPER_STEP_DECODER_PERIOD_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stepper_step_decoder_if bus_m ();
  stepper_step_decoder_if bus_s ();

  stepper_step_decoder #(.TIMEOUT(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  stepper_step_decoder #(.POS_WIDTH(8)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int          checks   = 0;
  int          failures = 0;
  int          strobes  = 0;
  int          model_pos = 0;
  int          sat_pos   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sat_q[$];

  function automatic logic [31:0] sm(input int v);
    logic [31:0] r;
    if (v < 0) r = {1'b1, 31'(-v)};
    else       r = 32'(v);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard pop on every strobe of either instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_m.step_strobe === 1'b1) begin
      strobes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe observed=strobe expected=none position=0x%08h", bus_m.position);
      end
      if (exp_q.size() != 0) check("strobe_position", bus_m.position, exp_q.pop_front());
    end
    if (rst_n === 1'b1 && bus_s.step_strobe === 1'b1) begin
      checks++;
      assert (sat_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_sat_strobe observed=strobe expected=none position=0x%08h", bus_s.position);
      end
      if (sat_q.size() != 0) check("sat_strobe_position", bus_s.position, sat_q.pop_front());
    end
  end

  task automatic pulse(input int hi, input int lo, input bit counted);
    bus_m.step_in = 1'b1;
    if (counted) begin
      model_pos = bus_m.dir_in ? model_pos - 1 : model_pos + 1;
      exp_q.push_back(sm(model_pos));
    end
    tick(hi);
    bus_m.step_in = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_sat();
    bus_s.step_in = 1'b1;
    if (sat_pos < 127) sat_pos++;
    sat_q.push_back(sm(sat_pos));
    tick(1);
    bus_s.step_in = 1'b0;
    tick(1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || sat_q.size() != 0) && n < 50) begin
      tick(1);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size() + sat_q.size()), 32'd0);
  endtask

  task automatic do_clear();
    bus_m.clear = 1'b1;
    tick(1);
    bus_m.clear = 1'b0;
    model_pos = 0;
    tick(2);
  endtask

  initial begin
    int snap;
    int n;
    int cnt;

    rst_n = 1'b0;
    bus_m.enable = 1'b0; bus_m.clear = 1'b0; bus_m.step_in = 1'b0; bus_m.dir_in = 1'b0;
    bus_s.enable = 1'b0; bus_s.clear = 1'b0; bus_s.step_in = 1'b0; bus_s.dir_in = 1'b0;
    tick(3);

    // Reset state
    check("rst_position",      bus_m.position,      32'd0);
    check("rst_step_strobe",   32'(bus_m.step_strobe), 32'd0);
    check("rst_moving",        32'(bus_m.moving),   32'd0);
    check("rst_step_period",   bus_m.step_period,   32'd0);
    check("rst_overspeed_err", 32'(bus_m.overspeed_err), 32'd0);
    check("rst_dir_err",       32'(bus_m.dir_err),  32'd0);
    check("rst_overflow_err",  32'(bus_m.overflow_err), 32'd0);

    rst_n = 1'b1;
    bus_m.enable = 1'b1;
    tick(5);

    // Up count: 10 pulses, 8-clock period
    for (int i = 0; i < 10; i++) pulse(4, 4, 1'b1);
    drain();
    check("up_position",     bus_m.position,    32'h0000000A);
    check("up_strobes",      32'(strobes),      32'd10);
    check("up_step_period",  bus_m.step_period, PER ? 32'd8 : 32'd0);
    check("up_overspeed",    32'(bus_m.overspeed_err), 32'd0);
    check("up_dir_err",      32'(bus_m.dir_err), 32'd0);
    check("up_overflow",     32'(bus_m.overflow_err), 32'd0);

    // Down through zero
    do_clear();
    check("clear_position",    bus_m.position,    32'd0);
    check("clear_step_period", bus_m.step_period, 32'd0);
    for (int i = 0; i < 3; i++) pulse(4, 4, 1'b1);
    bus_m.dir_in = 1'b1;
    tick(5);
    for (int i = 0; i < 5; i++) pulse(4, 4, 1'b1);
    drain();
    check("down_position", bus_m.position,     32'h80000002);
    check("down_dir_err",  32'(bus_m.dir_err), 32'd0);

    // Overspeed: one pair of edges 2 clocks apart, then slow steps
    do_clear();
    bus_m.dir_in = 1'b0;
    tick(5);
    pulse(4, 4, 1'b1);
    pulse(1, 1, 1'b1);
    pulse(4, 4, 1'b1);
    pulse(4, 4, 1'b1);
    drain();
    check("ovs_overspeed",   32'(bus_m.overspeed_err), PER ? 32'd1 : 32'd0);
    check("ovs_step_period", bus_m.step_period, PER ? 32'd8 : 32'd0);
    check("ovs_position",    bus_m.position,    32'd4);
    check("ovs_dir_err_pre", 32'(bus_m.dir_err), 32'd0);

    // Dir toggled one clock before a step
    bus_m.dir_in = 1'b1;
    tick(1);
    pulse(4, 4, 1'b1);
    drain();
    check("dset_dir_err",   32'(bus_m.dir_err), 32'd1);
    check("dset_position",  bus_m.position,     32'd3);
    check("dset_ovs_stick", 32'(bus_m.overspeed_err), PER ? 32'd1 : 32'd0);

    // Clear coincident with an edge, line left high after clear
    snap = strobes;
    bus_m.clear   = 1'b1;
    bus_m.step_in = 1'b1;
    model_pos = 0;
    tick(4);
    bus_m.clear = 1'b0;
    tick(4);
    bus_m.step_in = 1'b0;
    tick(4);
    check("clr_edge_position", bus_m.position,     32'd0);
    check("clr_edge_strobes",  32'(strobes),       32'(snap));
    check("clr_edge_dir_err",  32'(bus_m.dir_err), 32'd0);
    check("clr_edge_ovs",      32'(bus_m.overspeed_err), 32'd0);
    bus_m.dir_in = 1'b0;
    tick(5);

    // Enable low, then re-enable with the line high
    pulse(4, 4, 1'b1);
    snap = strobes;
    bus_m.enable = 1'b0;
    for (int i = 0; i < 5; i++) pulse(4, 4, 1'b0);
    bus_m.step_in = 1'b1;
    tick(4);
    bus_m.enable = 1'b1;
    tick(4);
    bus_m.step_in = 1'b0;
    tick(4);
    drain();
    check("en_position", bus_m.position, 32'd1);
    check("en_strobes",  32'(strobes),   32'(snap));

    // Reset in the middle of a pulse train
    pulse(4, 4, 1'b1);
    pulse(4, 4, 1'b1);
    drain();
    check("pre_rst_position", bus_m.position, 32'd3);
    bus_m.step_in = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_position",    bus_m.position,      32'd0);
    check("mid_rst_strobe",      32'(bus_m.step_strobe), 32'd0);
    check("mid_rst_moving",      32'(bus_m.moving),   32'd0);
    check("mid_rst_step_period", bus_m.step_period,   32'd0);
    check("mid_rst_dir_err",     32'(bus_m.dir_err),  32'd0);
    bus_m.step_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_pos = 0;
    tick(5);

    // Timeout: one step then idle
    bus_m.step_in = 1'b1;
    model_pos = 1;
    exp_q.push_back(sm(model_pos));
    tick(1);
    bus_m.step_in = 1'b0;
    n = 0;
    while (bus_m.step_strobe !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check("to_strobe_seen", 32'(bus_m.step_strobe), 32'd1);
    cnt = 0;
    while (bus_m.moving === 1'b1 && cnt < 100) begin
      cnt++;
      tick(1);
    end
    check("to_moving_cycles", 32'(cnt), PER ? 32'd20 : 32'd0);
    tick(10);
    check("to_moving_idle", 32'(bus_m.moving), 32'd0);

    // Saturation on the reduced-width instance (limit 127)
    bus_s.enable = 1'b1;
    tick(3);
    for (int i = 0; i < 126; i++) pulse_sat();
    drain();
    check("sat_pre_position", bus_s.position,          32'h0000007E);
    check("sat_pre_overflow", 32'(bus_s.overflow_err), 32'd0);
    pulse_sat();
    pulse_sat();
    drain();
    check("sat_position", bus_s.position,          32'h0000007F);
    check("sat_overflow", 32'(bus_s.overflow_err), 32'd1);
    check("main_overflow_clean", 32'(bus_m.overflow_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
